// File: rtl/uart_pkg.sv
// Shared UART definitions: baud FSM encodings, period floor and
// power-on bit configuration used by baud_generate and CtrlCore.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        UP_PHASE   = 2'd1,
        DOWN_PHASE = 2'd2
    } baudState_t;

    localparam logic [15:0] MIN_PERIOD_DEF = 16'd2;
    localparam logic [15:0] DEF_PERIOD     = 16'd20;
    localparam logic [3:0]  DEF_UP         = 4'd10;
    localparam logic [3:0]  DEF_DOWN       = 4'd5;

    function automatic logic [15:0] clampPeriod(
        input logic [15:0] p,
        input logic [15:0] minP
    );
        return (p < minP) ? minP : p;
    endfunction

    // First phase of a bit: round-up periods come first when present.
    function automatic baudState_t entryState(
        input logic [3:0] u,
        input logic [3:0] d
    );
        if (u != 4'd0)
            return UP_PHASE;
        else if (d != 4'd0)
            return DOWN_PHASE;
        else
            return IDLE;
    endfunction

endpackage

// File: rtl/baud_generate_acq_period_counter.sv
// Loadable down-counter; tc is high while the count sits at zero,
// so a load of L gives a terminal count every L+1 clocks.
module acq_period_counter #(
    parameter int W = 17
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clear,
    input  logic         load,
    input  logic [W-1:0] loadVal,
    output logic [W-1:0] count,
    output logic         tc
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            count <= '0;
        else if (clear)
            count <= '0;
        else if (load)
            count <= loadVal;
        else if (count != '0)
            count <= count - 1'b1;
    end

    assign tc = (count == '0);

endmodule

// File: rtl/baud_generate.sv
// Fractional baud generator: U periods of Ps+1 clocks then D periods
// of Ps clocks per bit, with restart realignment for Rx start edges.
module baud_generate
    import uart_pkg::*;
#(
    parameter logic [15:0] MIN_PERIOD = MIN_PERIOD_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] BaudRateGen_i,
    input  logic [7:0]  BitCompensation_i,
    input  logic        p_Enable_i,
    input  logic        p_Restart_i,
    output logic        p_AcqSig_o,
    output logic        p_BaudSig_o,
    output logic [4:0]  AcqIndex_o,
    output logic        p_Busy_o
);

    baudState_t state;
    baudState_t stateNext;

    logic [15:0] perSh;
    logic [3:0]  upSh;
    logic [3:0]  dnSh;
    logic [4:0]  acqIdx;

    logic [15:0] perIn;
    logic [3:0]  upIn;
    logic [3:0]  dnIn;
    logic [15:0] perNext;
    logic [4:0]  upLast;
    logic [4:0]  bitLast;

    logic        capture;
    logic        acqEnd;
    logic        bitEnd;
    logic        live;
    logic        cntClear;
    logic        cntLoad;
    logic [16:0] cntLoadVal;
    logic [16:0] cnt;
    logic        tc;

    assign perIn   = clampPeriod(BaudRateGen_i, MIN_PERIOD);
    assign upIn    = BitCompensation_i[7:4];
    assign dnIn    = BitCompensation_i[3:0];
    assign upLast  = {1'b0, upSh} - 5'd1;
    assign bitLast = {1'b0, upSh} + {1'b0, dnSh} - 5'd1;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            state <= IDLE;
        else
            state <= stateNext;
    end

    always_comb begin
        stateNext = state;
        capture   = 1'b0;
        bitEnd    = 1'b0;
        acqEnd    = (state != IDLE) && tc;
        if (!p_Enable_i) begin
            stateNext = IDLE;
        end else if (p_Restart_i || state == IDLE) begin
            capture   = 1'b1;
            stateNext = entryState(upIn, dnIn);
        end else if (acqEnd) begin
            case (state)
                UP_PHASE: begin
                    if (acqIdx == upLast) begin
                        if (dnSh != 4'd0)
                            stateNext = DOWN_PHASE;
                        else
                            bitEnd = 1'b1;
                    end
                end
                DOWN_PHASE: begin
                    if (acqIdx == bitLast)
                        bitEnd = 1'b1;
                end
                default: ;
            endcase
            if (bitEnd) begin
                capture   = 1'b1;
                stateNext = entryState(upIn, dnIn);
            end
        end
    end

    // Counter load of L yields an L+1 clock period.
    always_comb begin
        cntClear   = (stateNext == IDLE);
        cntLoad    = capture || acqEnd;
        perNext    = capture ? perIn : perSh;
        if (stateNext == UP_PHASE)
            cntLoadVal = {1'b0, perNext};
        else
            cntLoadVal = {1'b0, perNext} - 17'd1;
    end

    always_comb begin
        live        = p_Enable_i && !p_Restart_i && (state != IDLE);
        p_AcqSig_o  = live && tc;
        p_BaudSig_o = live && bitEnd;
        p_Busy_o    = (state != IDLE);
        AcqIndex_o  = acqIdx;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perSh  <= DEF_PERIOD;
            upSh   <= DEF_UP;
            dnSh   <= DEF_DOWN;
            acqIdx <= 5'd0;
        end else begin
            if (capture) begin
                perSh <= perIn;
                upSh  <= upIn;
                dnSh  <= dnIn;
            end
            if (!p_Enable_i || capture)
                acqIdx <= 5'd0;
            else if (acqEnd)
                acqIdx <= acqIdx + 5'd1;
        end
    end

    acq_period_counter #(
        .W(17)
    ) u_cnt (
        .clk     (clk),
        .rst     (rst),
        .clear   (cntClear),
        .load    (cntLoad),
        .loadVal (cntLoadVal),
        .count   (cnt),
        .tc      (tc)
    );

endmodule
